// File: rtl/motor_cmd_sequencer.sv
// Queues host motor commands and replays each one as data-setup, latch pulse and recovery gap.
// A batch ends with a trigger pulse, then waits for the core's completion edge or a timeout.
module motor_cmd_sequencer #(
    parameter int          FIFO_DEPTH      = 8,
    parameter int          FIFO_ADDR_WIDTH = 3,
    parameter int          SETUP_CYCLES    = 2,
    parameter int          PULSE_CYCLES    = 4,
    parameter logic [15:0] TIMEOUT_CYCLES  = 16'd50000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_word,
    input  logic                       cmd_last,
    output logic [31:0]                cmd_data,
    output logic                       latch_data,
    output logic                       control_trigger,
    input  logic                       update_cycle_complete,
    input  logic                       clear_timeout,
    output logic                       busy,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
    output logic                       timeout
);

    typedef enum logic [2:0] {
        IDLE, SETUP, LATCH, RECOVER, TRIGGER, WAIT_DONE
    } state_t;

    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = FIFO_DEPTH[FIFO_ADDR_WIDTH:0];

    state_t                     state, state_nxt;
    logic [32:0]                fifo_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   count;
    logic                       push, pop;
    logic [15:0]                timer, timer_load;
    logic                       last_flag, upd_prev, upd_rise, expire;
    logic                       latch_nxt, trig_nxt;

    assign cmd_ready  = !reset && (count < DEPTH_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign fifo_count = count;
    assign upd_rise   = update_cycle_complete && !upd_prev;
    assign expire     = (state == WAIT_DONE) && !upd_rise && (timer == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_last, cmd_word};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            cmd_data        <= '0;
            last_flag       <= 1'b0;
            latch_data      <= 1'b0;
            control_trigger <= 1'b0;
            upd_prev        <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_nxt;
            latch_data      <= latch_nxt;
            control_trigger <= trig_nxt;
            upd_prev        <= update_cycle_complete;
            if (state_nxt != state)  timer <= timer_load;
            else if (timer != '0)    timer <= timer - 1'b1;
            if (pop) begin
                cmd_data  <= fifo_mem[rd_ptr][31:0];
                last_flag <= fifo_mem[rd_ptr][32];
            end
            // Expiry takes priority over a simultaneous clear.
            if (expire)             timeout <= 1'b1;
            else if (clear_timeout) timeout <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (count != '0)  state_nxt = SETUP;
            SETUP:     if (timer == '0)  state_nxt = LATCH;
            LATCH:     if (timer == '0)  state_nxt = RECOVER;
            RECOVER:   if (timer == '0)  state_nxt = last_flag ? TRIGGER : IDLE;
            TRIGGER:   if (timer == '0)  state_nxt = WAIT_DONE;
            WAIT_DONE: if (upd_rise || timer == '0) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Timer holds remaining cycles minus one, so a load of N-1 gives an N-cycle state.
    always_comb begin
        timer_load = '0;
        latch_nxt  = (state_nxt == LATCH);
        trig_nxt   = (state_nxt == TRIGGER);
        busy       = (state != IDLE);
        case (state_nxt)
            SETUP:                   timer_load = 16'(SETUP_CYCLES - 1);
            LATCH, RECOVER, TRIGGER: timer_load = 16'(PULSE_CYCLES - 1);
            WAIT_DONE:               timer_load = TIMEOUT_CYCLES - 16'd1;
            default:                 timer_load = '0;
        endcase
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed timing steps plus random batches against a command-queue model.
module tb_motor_cmd_sequencer;
    localparam int PULSE = 4;
    localparam int TMO   = 20;

    logic        clock, reset, cmd_valid, cmd_ready, cmd_last;
    logic [31:0] cmd_word, cmd_data;
    logic        latch_data, control_trigger, update_cycle_complete, clear_timeout;
    logic        busy, timeout;
    logic [3:0]  fifo_count;

    motor_cmd_sequencer #(
        .FIFO_DEPTH(8), .FIFO_ADDR_WIDTH(3), .SETUP_CYCLES(2),
        .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(16'(TMO))
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_word(cmd_word), .cmd_last(cmd_last), .cmd_data(cmd_data),
        .latch_data(latch_data), .control_trigger(control_trigger),
        .update_cycle_complete(update_cycle_complete), .clear_timeout(clear_timeout),
        .busy(busy), .fifo_count(fifo_count), .timeout(timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [31:0] held;
    logic        last_seen = 1'b0;
    logic        prev_lat = 1'b0, prev_trg = 1'b0;
    int          lat_run = 0, trg_run = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    // Advance one edge and audit pulses against the queue of expected commands.
    task automatic tick();
        @(posedge clock);
        #1;
        if (reset) begin
            prev_lat = 1'b0; prev_trg = 1'b0; lat_run = 0; trg_run = 0;
        end else begin
            if (latch_data && !prev_lat) begin
                chk1("latch_has_entry", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk32("latch_order", cmd_data, e[31:0]);
                    last_seen = e[32];
                end
                held = cmd_data;
                lat_run = 1;
            end else if (latch_data) begin
                lat_run++;
                chk32("latch_hold", cmd_data, held);
            end else if (prev_lat) begin
                chk32("latch_width", 32'(lat_run), 32'(PULSE));
            end
            if (control_trigger && !prev_trg) begin
                chk1("trig_after_last", last_seen, 1'b1);
                trg_run = 1;
            end else if (control_trigger) begin
                trg_run++;
            end else if (prev_trg) begin
                chk32("trig_width", 32'(trg_run), 32'(PULSE));
            end
            prev_lat = latch_data;
            prev_trg = control_trigger;
        end
    endtask

    task automatic push(input logic [31:0] w, input logic l);
        int n;
        n = 0;
        cmd_word = w; cmd_last = l; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        chk1("push_ready", cmd_ready, 1'b1);
        if (cmd_ready) exp_q.push_back({l, w});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_trig_fall();
        int n;
        n = 0;
        while (!control_trigger && n < 300) begin tick(); n++; end
        chk1("trig_rise_seen", control_trigger, 1'b1);
        n = 0;
        while (control_trigger && n < 20) begin tick(); n++; end
        chk1("trig_fall_seen", control_trigger, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || fifo_count != 0) && n < 400) begin tick(); n++; end
        chk1("drained_idle", busy || (fifo_count != 0), 1'b0);
    endtask

    initial begin
        logic [31:0] w9;
        int n, d, gap;
        reset = 1'b1; cmd_valid = 1'b0; cmd_word = '0; cmd_last = 1'b0;
        update_cycle_complete = 1'b0; clear_timeout = 1'b0;

        // Reset values
        tick(); tick();
        chk32("rst_cmd_data", cmd_data, 32'h0);
        chk1("rst_latch", latch_data, 1'b0);
        chk1("rst_trig", control_trigger, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_count", 32'(fifo_count), 32'h0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_ready", cmd_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk1("ready_after_rst", cmd_ready, 1'b1);

        // Single command: edge-exact timeline relative to the push edge
        cmd_word = 32'hA5A5_0001; cmd_last = 1'b0; cmd_valid = 1'b1;
        chk1("s_ready", cmd_ready, 1'b1);
        exp_q.push_back({1'b0, 32'hA5A5_0001});
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            chk1("s_latch", latch_data, (k >= 3 && k <= 6));
            chk1("s_busy", busy, (k >= 1 && k <= 10));
            chk1("s_trig", control_trigger, 1'b0);
            chk32("s_count", 32'(fifo_count), 32'(k == 0));
            if (k >= 1) chk32("s_cmd_data", cmd_data, 32'hA5A5_0001);
            tick();
        end

        // Batch of three, completion ten cycles after trigger ends
        push($urandom, 1'b0); push($urandom, 1'b0); push($urandom, 1'b1);
        wait_trig_fall();
        for (int k = 0; k < 10; k++) begin
            chk1("b_wait_busy", busy, 1'b1);
            tick();
        end
        update_cycle_complete = 1'b1;
        tick();
        chk1("b_done_idle", busy, 1'b0);
        update_cycle_complete = 1'b0;
        chk32("b_queue_empty", 32'(exp_q.size()), 32'h0);

        // Full FIFO while stalled in WAIT_DONE
        push($urandom, 1'b1);
        wait_trig_fall();
        chk32("f_count0", 32'(fifo_count), 32'h0);
        for (int k = 0; k < 8; k++) push($urandom, 1'b0);
        chk1("f_ready_full", cmd_ready, 1'b0);
        chk32("f_count_full", 32'(fifo_count), 32'h8);
        w9 = $urandom;
        cmd_word = w9; cmd_last = 1'b0; cmd_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk32("f_count_hold", 32'(fifo_count), 32'h8);
            chk1("f_ready_hold", cmd_ready, 1'b0);
        end
        update_cycle_complete = 1'b1;
        tick();
        update_cycle_complete = 1'b0;
        chk1("f_idle", busy, 1'b0);
        chk1("f_ready_still0", cmd_ready, 1'b0);
        tick();
        chk32("f_count_pop", 32'(fifo_count), 32'h7);
        chk1("f_ready_freed", cmd_ready, 1'b1);
        exp_q.push_back({1'b0, w9});
        tick();
        cmd_valid = 1'b0;
        chk32("f_count_9th", 32'(fifo_count), 32'h8);
        wait_idle();
        chk32("f_queue_empty", 32'(exp_q.size()), 32'h0);

        // Timeout expiry, then clear
        push($urandom, 1'b1);
        wait_trig_fall();
        chk1("t_before", timeout, 1'b0);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            chk1("t_flag", timeout, (k >= TMO));
            chk1("t_busy", busy, (k < TMO));
        end
        clear_timeout = 1'b1;
        tick();
        clear_timeout = 1'b0;
        chk1("t_cleared", timeout, 1'b0);

        // Clear coincident with expiry: set wins
        push($urandom, 1'b1);
        wait_trig_fall();
        for (int k = 1; k <= TMO; k++) begin
            clear_timeout = (k == TMO);
            tick();
        end
        clear_timeout = 1'b0;
        chk1("t_set_wins", timeout, 1'b1);
        clear_timeout = 1'b1;
        tick();
        clear_timeout = 1'b0;
        chk1("t_cleared2", timeout, 1'b0);

        // Stray completion edges outside WAIT_DONE are ignored
        push($urandom, 1'b1);
        for (int k = 0; k < 8; k++) begin
            update_cycle_complete = ~update_cycle_complete;
            tick();
        end
        update_cycle_complete = 1'b0;
        n = 0;
        while (!control_trigger && n < 100) begin tick(); n++; end
        chk1("x_trig_rise", control_trigger, 1'b1);
        tick(); tick(); tick();
        chk1("x_trig_last", control_trigger, 1'b1);
        update_cycle_complete = 1'b1;
        tick();
        chk1("x_trig_end", control_trigger, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk1("x_still_wait", busy, 1'b1);
            tick();
        end
        update_cycle_complete = 1'b0;
        tick();
        update_cycle_complete = 1'b1;
        tick();
        chk1("x_fresh_edge", busy, 1'b0);
        update_cycle_complete = 1'b0;

        // Reset mid-LATCH with three entries queued
        for (int k = 0; k < 4; k++) push($urandom, 1'b0);
        n = 0;
        while (!latch_data && n < 20) begin tick(); n++; end
        chk1("r_in_latch", latch_data, 1'b1);
        chk32("r_queued", 32'(fifo_count), 32'h3);
        reset = 1'b1;
        #1;
        chk1("r_latch", latch_data, 1'b0);
        chk32("r_cmd_data", cmd_data, 32'h0);
        chk32("r_count", 32'(fifo_count), 32'h0);
        chk1("r_busy", busy, 1'b0);
        chk1("r_ready_low", cmd_ready, 1'b0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        #1;
        chk1("r_ready_high", cmd_ready, 1'b1);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk1("r_no_replay", busy || latch_data, 1'b0);
        end

        // Random batches, completion edge after a random delay (0 = first WAIT_DONE cycle)
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) tick();
                push($urandom, (i == n - 1));
            end
            wait_trig_fall();
            d = $urandom_range(0, 5);
            repeat (d) begin
                chk1("rnd_wait_busy", busy, 1'b1);
                tick();
            end
            update_cycle_complete = 1'b1;
            tick();
            chk1("rnd_done_idle", busy, 1'b0);
            update_cycle_complete = 1'b0;
            tick();
        end
        chk32("rnd_queue_empty", 32'(exp_q.size()), 32'h0);
        chk1("rnd_no_timeout", timeout, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Buffers 32-bit motor commands from a host-side source (SPI front end or test master) in a small FIFO.
- Replays each command into the controller core's command path: drives the command word, then pulses the latch strobe.
- After the last command of a batch, pulses the control trigger and waits for the core's update-cycle-complete indication before starting the next batch.
- All pulses are wide enough to pass the core's 3-sample input qualifiers.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, 2..64.
- FIFO_ADDR_WIDTH, 3, log2(FIFO_DEPTH).
- SETUP_CYCLES, 2, cycles cmd_data is stable before latch_data rises; >=1.
- PULSE_CYCLES, 4, high time of latch_data and control_trigger, and low time after each latch pulse; >=3.
- TIMEOUT_CYCLES, 16'd50000, max wait for update_cycle_complete; >=1, fits 16 bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_word  in  32  host command word.
- cmd_last  in  1  word ends a batch; control trigger follows it.
- cmd_data  out  32  command word presented to the core.
- latch_data  out  1  latch strobe to the core.
- control_trigger  out  1  trigger strobe to the core.
- update_cycle_complete  in  1  core cycle-done level, synchronous to clock.
- clear_timeout  in  1  clears the sticky timeout flag.
- busy  out  1  FSM is not IDLE.
- fifo_count  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy.
- timeout  out  1  sticky: WAIT_DONE expired.

Behaviour:
- Reset (asynchronous): FIFO flushed; FSM to IDLE; timer 0. Output values during reset: cmd_data=0, latch_data=0, control_trigger=0, busy=0, fifo_count=0, timeout=0, cmd_ready=0 while reset is high, cmd_ready=1 after release. Reset in any state aborts the operation in progress; a partially issued batch is lost.
- FIFO:
  - Entries are {cmd_last, cmd_word}, 33 bits.
  - Push on cmd_valid & cmd_ready. cmd_ready = (fifo_count < FIFO_DEPTH), combinational from the count.
  - Pop only in IDLE when count != 0. Same-cycle push and pop leaves the count unchanged.
  - When full, cmd_ready=0 and a pop frees a slot from the next cycle. Pointers wrap modulo FIFO_DEPTH.
  - No overflow or underflow is possible.
- Timer: one 16-bit counter, loaded on each state entry, decremented each cycle.
- FSM states:
  - IDLE: if count!=0, pop the head; cmd_data <= word; register last_flag <= entry last bit; go to SETUP. cmd_data then holds its value until the next pop.
  - SETUP: SETUP_CYCLES cycles, latch_data=0; then go to LATCH.
  - LATCH: latch_data=1 for exactly PULSE_CYCLES cycles; then go to RECOVER.
  - RECOVER: latch_data=0 for PULSE_CYCLES cycles. Then go to TRIGGER if last_flag is set, else IDLE.
  - TRIGGER: control_trigger=1 for PULSE_CYCLES cycles; then go to WAIT_DONE.
  - WAIT_DONE: leave on a rising edge of update_cycle_complete, detected against a previous-sample register that is updated every cycle.
    - A rising edge in the first WAIT_DONE cycle counts.
    - Edges in any other state are ignored.
    - If TIMEOUT_CYCLES elapse first, set timeout=1 and go to IDLE.
    - Otherwise go to IDLE on the edge.
- Latch timing: latch_data and control_trigger are registered outputs. latch_data rises SETUP_CYCLES cycles after the cmd_data update edge.
- Latency: a command pushed at edge N into an empty FIFO in IDLE is popped at edge N+1, with cmd_data updating at N+1.
- timeout flag:
  - Sticky; cleared only by clear_timeout or reset.
  - clear_timeout and a timeout expiry in the same cycle: the flag ends set (set wins).
- Ordering: cmd_data never changes while latch_data=1 or during SETUP/RECOVER. Commands are issued strictly in FIFO order.

Test Plan:
- Reset: assert reset mid-LATCH with 3 entries queued -> latch_data=0, cmd_data=0, fifo_count=0, busy=0 immediately; after release, cmd_ready=1.
- Single command: push 0xA5A5_0001 with last=0 at edge 0 -> cmd_data=0xA5A5_0001 from edge 1; latch_data high on edges 3..6 (4 cycles); IDLE at edge 11; control_trigger never asserted.
- Batch: push 3 words, last on the third -> three latch pulses in order; then control_trigger high 4 cycles; busy stays 1. Pulse update_cycle_complete 0->1 10 cycles later -> IDLE next edge, busy=0.
- Full FIFO: push 9 words back-to-back with the FSM stalled in WAIT_DONE -> cmd_ready=0 after the 8th push, fifo_count=8; the 9th word is accepted only after the next pop.
- Timeout: TIMEOUT_CYCLES=20, no completion -> timeout=1 exactly 20 cycles after WAIT_DONE entry, FSM to IDLE. clear_timeout=1 -> timeout=0 next edge.
- Stray completion: toggle update_cycle_complete during SETUP and LATCH -> no state effect; a batch still waits for a fresh rising edge in WAIT_DONE.
